// File: rtl/puf_resp_uart_tx_if.sv
// Handshake and serial-side signal bundle for the PUF response UART transmitter.
// The master side is the PUF top level; the slave side is the transmitter itself.
interface puf_resp_uart_tx_if #(
    parameter int RESP_W = 64
);
    logic [RESP_W-1:0] resp_in;
    logic              resp_valid;
    logic              resp_ready;
    logic              uart_tx;
    logic              busy;
    logic              frame_done;

    modport master (
        output resp_in,
        output resp_valid,
        input  resp_ready,
        input  uart_tx,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  resp_in,
        input  resp_valid,
        output resp_ready,
        output uart_tx,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/puf_resp_uart_tx.sv
// Frames each PUF response as HEADER, RESP_BYTES data bytes (LSB first) and an XOR checksum,
// and shifts it out as 8N1 UART with no idle gap between the bytes of one frame.
module puf_resp_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          RESP_W       = 64,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic                 clk_ref,
    input  logic                 rst_n,
    puf_resp_uart_tx_if.slave    bus
);
    localparam int RESP_BYTES = RESP_W / 8;
    localparam int BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W     = $clog2(RESP_BYTES + 2);

    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] LAST_IDX = BYTE_W'(RESP_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // XOR of all response bytes; the header is not part of the checksum.
    function automatic logic [7:0] resp_checksum(input logic [RESP_W-1:0] resp);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < RESP_BYTES; k++) begin
            c = c ^ resp[8*k +: 8];
        end
        return c;
    endfunction

    function automatic logic [7:0] frame_byte(
        input logic [BYTE_W-1:0] idx,
        input logic [RESP_W-1:0] resp,
        input logic [7:0]        csum
    );
        logic [7:0] b;
        b = HEADER;
        for (int k = 1; k <= RESP_BYTES; k++) begin
            b = (idx == BYTE_W'(k)) ? resp[8*(k-1) +: 8] : b;
        end
        b = (idx == LAST_IDX) ? csum : b;
        return b;
    endfunction

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit;
    logic [BYTE_W-1:0]   r_byte;
    logic [7:0]          r_shift;
    logic [RESP_W-1:0]   r_resp;
    logic [7:0]          r_csum;
    logic                r_tx;
    logic                r_busy;
    logic                r_frame_done;

    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [2:0]          w_bit_nxt;
    logic [BYTE_W-1:0]   w_byte_nxt;
    logic [7:0]          w_shift_nxt;
    logic [RESP_W-1:0]   w_resp_nxt;
    logic [7:0]          w_csum_nxt;
    logic                w_tx_nxt;
    logic                w_done_nxt;
    logic                w_baud_end;

    // Next-state, counter and serial-bit decode for the framing FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_shift_nxt = r_shift;
        w_resp_nxt  = r_resp;
        w_csum_nxt  = r_csum;
        w_done_nxt  = 1'b0;
        w_tx_nxt    = 1'b1;
        w_baud_end  = (r_baud == BAUD_MAX);

        case (r_state)
            ST_IDLE: begin
                w_baud_nxt = '0;
                if (bus.resp_valid) begin
                    w_state_nxt = ST_START;
                    w_resp_nxt  = bus.resp_in;
                    w_csum_nxt  = resp_checksum(bus.resp_in);
                    w_byte_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_shift_nxt = HEADER;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_byte == LAST_IDX) begin
                        // Return to IDLE together with the done pulse so the next
                        // response can be accepted on the frame_done edge.
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_byte_nxt  = r_byte + BYTE_W'(1);
                        w_shift_nxt = frame_byte(r_byte + BYTE_W'(1), r_resp, r_csum);
                        w_state_nxt = ST_START;
                    end
                end else begin
                    w_baud_nxt = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_baud_nxt  = '0;
            end
        endcase

        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // State, datapath and registered output update with synchronous reset.
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_baud       <= '0;
            r_bit        <= 3'd0;
            r_byte       <= '0;
            r_shift      <= 8'h00;
            r_resp       <= '0;
            r_csum       <= 8'h00;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_baud       <= w_baud_nxt;
            r_bit        <= w_bit_nxt;
            r_byte       <= w_byte_nxt;
            r_shift      <= w_shift_nxt;
            r_resp       <= w_resp_nxt;
            r_csum       <= w_csum_nxt;
            r_tx         <= w_tx_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_done <= w_done_nxt;
        end
    end

    assign bus.uart_tx    = r_tx;
    assign bus.busy       = r_busy;
    assign bus.resp_ready = ~r_busy;
    assign bus.frame_done = r_frame_done;
endmodule
